// File: rtl/xbus_pkg.sv
// Shared types and constants for the data-bus fabric: FSM encoding,
// status register field positions and the default error read data.
package xbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int CNT_MSB = 31;
  localparam int CNT_LSB = 24;
  localparam int TO_BIT  = 17;
  localparam int UM_BIT  = 16;

  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  // Error counter sticks at its maximum instead of wrapping back to zero.
  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/xbus_if.sv
// Bundle of the CPU data bus and the per-slave signals seen by the fabric.
// master = CPU plus peripherals, slave = the fabric itself.
interface xbus_if #(
  parameter int NSLAVES = 4
) ();

  logic [31:0]           wb_dbus_adr;
  logic [31:0]           wb_dbus_dat;
  logic [3:0]            wb_dbus_sel;
  logic                  wb_dbus_we;
  logic                  wb_dbus_cyc;
  logic [31:0]           wb_xbus_rdt;
  logic                  wb_xbus_ack;
  logic [NSLAVES-1:0]    s_cyc;
  logic [NSLAVES*32-1:0] s_rdt;
  logic [NSLAVES-1:0]    s_ack;
  logic                  irq;

  modport master (
    output wb_dbus_adr, wb_dbus_dat, wb_dbus_sel, wb_dbus_we, wb_dbus_cyc,
    output s_rdt, s_ack,
    input  wb_xbus_rdt, wb_xbus_ack, s_cyc, irq
  );

  modport slave (
    input  wb_dbus_adr, wb_dbus_dat, wb_dbus_sel, wb_dbus_we, wb_dbus_cyc,
    input  s_rdt, s_ack,
    output wb_xbus_rdt, wb_xbus_ack, s_cyc, irq
  );

endinterface

// File: rtl/xbus_decode.sv
// Combinational address decoder: top address field -> one-hot slave select,
// status-register hit or unmapped. Lowest matching slave index wins.
module xbus_decode #(
  parameter int                       NSLAVES   = 4,
  parameter int                       AWIDTH    = 8,
  parameter logic [NSLAVES*AWIDTH-1:0] BASES    = 32'h7060_5040,
  parameter logic [AWIDTH-1:0]        STAT_ADDR = 8'h7F
) (
  input  logic [AWIDTH-1:0]  i_field,
  output logic [NSLAVES-1:0] o_sel,
  output logic               o_isStat,
  output logic               o_isUnmapped
);

  logic w_hit;

  // Slaves are checked before the status address so an overlapping base shadows it.
  always_comb begin
    o_sel = '0;
    w_hit = 1'b0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (!w_hit && (i_field == BASES[i*AWIDTH +: AWIDTH])) begin
        o_sel[i] = 1'b1;
        w_hit    = 1'b1;
      end
    end
    o_isStat     = !w_hit && (i_field == STAT_ADDR);
    o_isUnmapped = !w_hit && !o_isStat;
  end

endmodule

// File: rtl/xbus_fabric.sv
// Wishbone data-bus fabric: routes each CPU access to one decoded slave,
// registers the response, times out hung/unmapped accesses and logs faults.
module xbus_fabric
  import xbus_pkg::*;
#(
  parameter int                        NSLAVES   = 4,
  parameter int                        AWIDTH    = 8,
  parameter logic [NSLAVES*AWIDTH-1:0] BASES     = 32'h7060_5040,
  parameter logic [AWIDTH-1:0]         STAT_ADDR = 8'h7F,
  parameter int                        TIMEOUT   = 255,
  parameter logic [31:0]               ERR_DATA  = DEF_ERR_DATA
) (
  input logic   wb_clk,
  input logic   wb_rst,
  xbus_if.slave bus
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next;
  logic [NSLAVES-1:0] r_sel;
  logic [15:0]        r_cnt;
  logic [31:0]        r_rdt;
  logic [7:0]         r_errCnt;
  logic               r_toFlag;
  logic               r_umFlag;
  logic [15:0]        r_faultAdr;

  logic [NSLAVES-1:0] w_decSel;
  logic               w_isStat;
  logic               w_isUnmapped;
  logic               w_slvAck;
  logic [31:0]        w_slvRdt;
  logic [31:0]        w_statWord;
  logic [NSLAVES-1:0] w_sCyc;
  logic               w_ack;
  logic               w_startSlave;
  logic               w_startLocal;
  logic               w_gotAck;
  logic               w_toFault;
  logic               w_umFault;
  logic               w_statWr;
  logic               w_statRd;
  logic               w_unused;

  xbus_decode #(
    .NSLAVES  (NSLAVES),
    .AWIDTH   (AWIDTH),
    .BASES    (BASES),
    .STAT_ADDR(STAT_ADDR)
  ) u_decode (
    .i_field     (bus.wb_dbus_adr[31:32-AWIDTH]),
    .o_sel       (w_decSel),
    .o_isStat    (w_isStat),
    .o_isUnmapped(w_isUnmapped)
  );

  assign w_unused = ^{bus.wb_dbus_sel, bus.wb_dbus_dat, bus.wb_dbus_adr};

  // Acks and data from slaves other than the latched one never reach the CPU.
  always_comb begin
    w_slvRdt = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (r_sel[i]) w_slvRdt = w_slvRdt | bus.s_rdt[i*32 +: 32];
    end
  end
  assign w_slvAck = |(bus.s_ack & r_sel);

  always_comb begin
    w_statWord                  = '0;
    w_statWord[CNT_MSB:CNT_LSB] = r_errCnt;
    w_statWord[TO_BIT]          = r_toFlag;
    w_statWord[UM_BIT]          = r_umFlag;
    w_statWord[15:0]            = r_faultAdr;
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_sCyc = '0;
    w_ack  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.wb_dbus_cyc) w_next = (|w_decSel) ? ST_ACTIVE : ST_DONE;
      end
      ST_ACTIVE: begin
        w_sCyc = r_sel & {NSLAVES{bus.wb_dbus_cyc}};
        if (!bus.wb_dbus_cyc)            w_next = ST_IDLE;
        else if (w_slvAck)               w_next = ST_DONE;
        else if (r_cnt == CNT_LAST)      w_next = ST_DONE;
      end
      ST_DONE: begin
        w_ack  = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_startSlave = (r_state == ST_IDLE) && bus.wb_dbus_cyc && (|w_decSel);
  assign w_startLocal = (r_state == ST_IDLE) && bus.wb_dbus_cyc && !(|w_decSel);
  assign w_gotAck     = (r_state == ST_ACTIVE) && bus.wb_dbus_cyc && w_slvAck;
  assign w_toFault    = (r_state == ST_ACTIVE) && bus.wb_dbus_cyc && !w_slvAck &&
                        (r_cnt == CNT_LAST);
  assign w_umFault    = w_startLocal && w_isUnmapped;
  assign w_statWr     = w_startLocal && w_isStat && bus.wb_dbus_we;
  assign w_statRd     = w_startLocal && w_isStat && !bus.wb_dbus_we;

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      r_sel      <= '0;
      r_cnt      <= '0;
      r_rdt      <= '0;
      r_errCnt   <= '0;
      r_toFlag   <= 1'b0;
      r_umFlag   <= 1'b0;
      r_faultAdr <= '0;
    end else begin
      if (w_startSlave) begin
        r_sel <= w_decSel;
        r_cnt <= '0;
      end else if (r_state == ST_ACTIVE) begin
        r_cnt <= r_cnt + 16'd1;
      end

      if (w_gotAck)                    r_rdt <= w_slvRdt;
      else if (w_toFault || w_umFault) r_rdt <= ERR_DATA;
      else if (w_statRd)               r_rdt <= w_statWord;
      else if (r_state == ST_DONE)     r_rdt <= '0;

      // A fault landing together with a status clear restarts the log at one entry.
      if (w_toFault || w_umFault) begin
        r_errCnt   <= w_statWr ? 8'd1 : satInc8(r_errCnt);
        r_toFlag   <= w_toFault || (r_toFlag && !w_statWr);
        r_umFlag   <= w_umFault || (r_umFlag && !w_statWr);
        r_faultAdr <= bus.wb_dbus_adr[15:0];
      end else if (w_statWr) begin
        r_errCnt   <= '0;
        r_toFlag   <= 1'b0;
        r_umFlag   <= 1'b0;
        r_faultAdr <= '0;
      end
    end
  end

  assign bus.s_cyc       = w_sCyc;
  assign bus.wb_xbus_ack = w_ack;
  assign bus.wb_xbus_rdt = r_rdt;
  assign bus.irq         = r_toFlag | r_umFlag;

endmodule

// File: tb/tb_xbus_fabric.sv
// Self-checking bench for xbus_fabric: directed scenarios followed by random
// traffic, all predicted by a transaction-level model of the fabric.
module tb_xbus_fabric;

  localparam int          NS   = 4;
  localparam int          TO   = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam logic [7:0]  BASE [NS] = '{8'h40, 8'h50, 8'h60, 8'h70};

  logic wb_clk = 1'b0;
  logic wb_rst = 1'b0;

  int nAssert = 0;
  int nFail   = 0;

  logic [7:0]  mCnt = 8'd0;
  logic        mTo  = 1'b0;
  logic        mUm  = 1'b0;
  logic [15:0] mAdr = 16'd0;

  xbus_if #(.NSLAVES(NS)) bus ();
  xbus_if #(.NSLAVES(NS)) bus2 ();

  xbus_fabric #(.NSLAVES(NS), .TIMEOUT(TO)) dut (
    .wb_clk(wb_clk),
    .wb_rst(wb_rst),
    .bus   (bus)
  );

  // Second fabric with slave0 and slave2 sharing base 0x60, fed the same traffic.
  xbus_fabric #(.NSLAVES(NS), .TIMEOUT(TO), .BASES(32'h7060_5060)) dut2 (
    .wb_clk(wb_clk),
    .wb_rst(wb_rst),
    .bus   (bus2)
  );

  assign bus2.wb_dbus_adr = bus.wb_dbus_adr;
  assign bus2.wb_dbus_dat = bus.wb_dbus_dat;
  assign bus2.wb_dbus_sel = bus.wb_dbus_sel;
  assign bus2.wb_dbus_we  = bus.wb_dbus_we;
  assign bus2.wb_dbus_cyc = bus.wb_dbus_cyc;
  assign bus2.s_rdt       = bus.s_rdt;
  assign bus2.s_ack       = bus.s_ack;

  always #5 wb_clk = ~wb_clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelStatus();
    return {mCnt, 6'd0, mTo, mUm, mAdr};
  endfunction

  function automatic bit isMapped(input logic [7:0] f);
    return (f == 8'h40) || (f == 8'h50) || (f == 8'h60) || (f == 8'h70) || (f == 8'h7F);
  endfunction

  task automatic modelFault(input bit isTo, input logic [15:0] a);
    if (mCnt != 8'hFF) mCnt = mCnt + 8'd1;
    if (isTo) mTo = 1'b1;
    else      mUm = 1'b1;
    mAdr = a;
  endtask

  task automatic modelClear();
    mCnt = 8'd0;
    mTo  = 1'b0;
    mUm  = 1'b0;
    mAdr = 16'd0;
  endtask

  // One complete CPU access; the addressed slave acks after 'delay' cycles of s_cyc.
  task automatic applyStimulus(input logic [31:0] adr, input bit we, input logic [31:0] dat,
                               input int delay, input logic [31:0] sdata);
    int          idx;
    bit          isStat;
    bit          seen;
    int          lat;
    int          expLat;
    logic [31:0] rdtObs;
    logic [31:0] expRdt;
    logic [3:0]  expSc;
    logic [3:0]  noise;
    bit          checkRdt;

    idx = -1;
    for (int i = 0; i < NS; i++) if (idx < 0 && adr[31:24] == BASE[i]) idx = i;
    isStat   = (idx < 0) && (adr[31:24] == 8'h7F);
    checkRdt = 1'b1;
    expSc    = (idx >= 0) ? 4'(1 << idx) : 4'd0;
    if (idx >= 0) begin
      if (delay <= TO - 1) begin
        expLat = delay + 2;
        expRdt = sdata;
      end else begin
        expLat = TO + 1;
        expRdt = ERRD;
      end
    end else if (isStat) begin
      expLat   = 1;
      expRdt   = modelStatus();
      checkRdt = !we;
    end else begin
      expLat = 1;
      expRdt = ERRD;
    end

    @(negedge wb_clk);
    bus.wb_dbus_adr = adr;
    bus.wb_dbus_we  = we;
    bus.wb_dbus_dat = dat;
    bus.wb_dbus_sel = 4'($urandom_range(0, 15));
    bus.wb_dbus_cyc = 1'b1;

    seen   = 1'b0;
    lat    = 0;
    rdtObs = '0;
    for (int n = 1; n <= TO + 8 && !seen; n++) begin
      @(negedge wb_clk);
      if (n == 1) checkOutput("s_cyc_select", 32'(bus.s_cyc), 32'(expSc));
      if (bus.wb_xbus_ack) begin
        seen   = 1'b1;
        lat    = n;
        rdtObs = bus.wb_xbus_rdt;
        checkOutput("s_cyc_in_done", 32'(bus.s_cyc), 32'd0);
      end else if (idx >= 0) begin
        noise = 4'($urandom_range(0, 15));
        noise[idx] = 1'b0;
        for (int i = 0; i < NS; i++) bus.s_rdt[i*32 +: 32] = $urandom;
        if (n - 1 == delay) begin
          noise[idx] = 1'b1;
          bus.s_rdt[idx*32 +: 32] = sdata;
        end
        bus.s_ack = noise;
      end
    end
    bus.wb_dbus_cyc = 1'b0;
    bus.s_ack       = '0;

    checkOutput("ack_seen", 32'(seen), 32'd1);
    checkOutput("ack_latency", 32'(lat), 32'(expLat));
    if (checkRdt) checkOutput("read_data", rdtObs, expRdt);

    if (idx >= 0 && delay > TO - 1)  modelFault(1'b1, adr[15:0]);
    else if (idx < 0 && !isStat)     modelFault(1'b0, adr[15:0]);
    else if (isStat && we)           modelClear();

    @(negedge wb_clk);
    checkOutput("ack_single_pulse", 32'(bus.wb_xbus_ack), 32'd0);
    checkOutput("rdt_cleared_idle", bus.wb_xbus_rdt, 32'd0);
    checkOutput("irq_level", 32'(bus.irq), 32'(mTo | mUm));
  endtask

  initial begin
    logic [31:0] a;
    int          kind;

    bus.wb_dbus_adr = '0;
    bus.wb_dbus_dat = '0;
    bus.wb_dbus_sel = '0;
    bus.wb_dbus_we  = 1'b0;
    bus.wb_dbus_cyc = 1'b0;
    bus.s_rdt       = '0;
    bus.s_ack       = '0;

    #3;
    checkOutput("reset_s_cyc", 32'(bus.s_cyc), 32'd0);
    checkOutput("reset_ack", 32'(bus.wb_xbus_ack), 32'd0);
    checkOutput("reset_rdt", bus.wb_xbus_rdt, 32'd0);
    checkOutput("reset_irq", 32'(bus.irq), 32'd0);
    @(negedge wb_clk);
    wb_rst = 1'b1;

    $display("[TB] slave1 read, unmapped read, status read");
    applyStimulus(32'h5000_0000, 1'b0, 32'd0, 3, 32'h1234_5678);
    applyStimulus(32'h9000_0000, 1'b0, 32'd0, 0, 32'd0);
    applyStimulus(32'h7F00_0000, 1'b0, 32'd0, 0, 32'd0);

    $display("[TB] slave0 timeout and late ack");
    applyStimulus(32'h4000_0004, 1'b0, 32'd0, 1000, 32'd0);
    repeat (3) begin
      @(negedge wb_clk);
      bus.s_ack = 4'b0001;
      @(negedge wb_clk);
      checkOutput("late_ack_ignored", 32'(bus.wb_xbus_ack), 32'd0);
    end
    bus.s_ack = '0;
    applyStimulus(32'h7F00_0000, 1'b0, 32'd0, 0, 32'd0);

    $display("[TB] status clear, ack on timeout cycle");
    applyStimulus(32'h7F00_0000, 1'b1, 32'hFFFF_FFFF, 0, 32'd0);
    applyStimulus(32'h7F00_0000, 1'b0, 32'd0, 0, 32'd0);
    applyStimulus(32'h7000_0010, 1'b0, 32'd0, TO - 1, 32'hCAFE_F00D);

    $display("[TB] overlapping bases and abort");
    @(negedge wb_clk);
    bus.wb_dbus_adr = 32'h6000_0000;
    bus.wb_dbus_we  = 1'b0;
    bus.wb_dbus_cyc = 1'b1;
    @(negedge wb_clk);
    checkOutput("overlap_default_s_cyc", 32'(bus.s_cyc), 32'h4);
    checkOutput("overlap_lowest_wins", 32'(bus2.s_cyc), 32'h1);
    bus.wb_dbus_cyc = 1'b0;
    repeat (3) begin
      @(negedge wb_clk);
      checkOutput("abort_no_ack", 32'(bus.wb_xbus_ack), 32'd0);
      checkOutput("abort_no_flag", 32'(bus.irq), 32'(mTo | mUm));
    end

    $display("[TB] async reset mid-transaction");
    applyStimulus(32'hA000_0000, 1'b0, 32'd0, 0, 32'd0);
    @(negedge wb_clk);
    bus.wb_dbus_adr = 32'h5000_0000;
    bus.wb_dbus_cyc = 1'b1;
    repeat (2) @(negedge wb_clk);
    #2 wb_rst = 1'b0;
    #1;
    checkOutput("midreset_s_cyc", 32'(bus.s_cyc), 32'd0);
    checkOutput("midreset_ack", 32'(bus.wb_xbus_ack), 32'd0);
    checkOutput("midreset_rdt", bus.wb_xbus_rdt, 32'd0);
    checkOutput("midreset_irq", 32'(bus.irq), 32'd0);
    modelClear();
    @(negedge wb_clk);
    bus.wb_dbus_cyc = 1'b0;
    wb_rst = 1'b1;
    repeat (3) begin
      @(negedge wb_clk);
      checkOutput("post_reset_no_ack", 32'(bus.wb_xbus_ack), 32'd0);
    end
    applyStimulus(32'h5000_0008, 1'b0, 32'd0, 2, 32'h0BAD_CAFE);

    $display("[TB] random traffic");
    for (int t = 0; t < 150; t++) begin
      a    = $urandom;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        a[31:24] = BASE[kind % NS];
        applyStimulus(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 19), $urandom);
      end else if (kind <= 7) begin
        a[31:24] = 8'h7F;
        applyStimulus(a, kind == 7, $urandom, 0, 32'd0);
      end else begin
        while (isMapped(a[31:24])) a[31:24] = 8'($urandom);
        applyStimulus(a, 1'($urandom_range(0, 1)), $urandom, 0, 32'd0);
      end
    end

    $display("[TB] error counter saturation");
    for (int t = 0; t < 300; t++) begin
      applyStimulus(32'h9000_0000 | 32'($urandom_range(0, 65535)), 1'b0, 32'd0, 0, 32'd0);
    end
    applyStimulus(32'h7F00_0000, 1'b0, 32'd0, 0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
